// File: rtl/imm_encoder_pkg.sv
// Shared immediate-format select codes and field-clear masks for the immediate encoder.
package imm_encoder_pkg;

  // Format select codes, identical to the decode-side immediate generator.
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  // Instruction bits owned by each format's immediate field.
  localparam logic [31:0] IMM_MASK_I = 32'hFFF00000;
  localparam logic [31:0] IMM_MASK_S = 32'hFE000F80;
  localparam logic [31:0] IMM_MASK_B = 32'hFE000F80;
  localparam logic [31:0] IMM_MASK_U = 32'hFFFFF000;
  localparam logic [31:0] IMM_MASK_J = 32'hFFFFF000;

endpackage

// File: rtl/imm_pack.sv
// Combinational immediate packer: merges a signed immediate into a base instruction word.
// Range flagging is built only when IMM_ENC_RANGE_CHK_EN is defined.
module imm_pack
  import imm_encoder_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [31:0]     inst,
  input  logic [2:0]      immsel,
  input  logic [XLEN-1:0] imm,
  output logic [31:0]     packed_inst,
  output logic            err
);

  always_comb begin
    packed_inst = inst;
    case (immsel)
      IMM_I: packed_inst = (inst & ~IMM_MASK_I) | {imm[11:0], 20'd0};
      IMM_S: packed_inst = (inst & ~IMM_MASK_S) | {imm[11:5], 13'd0, imm[4:0], 7'd0};
      IMM_B: packed_inst = (inst & ~IMM_MASK_B) |
                           {imm[12], imm[10:5], 13'd0, imm[4:1], imm[11], 7'd0};
      IMM_U: packed_inst = (inst & ~IMM_MASK_U) | {imm[31:12], 12'd0};
      IMM_J: packed_inst = (inst & ~IMM_MASK_J) |
                           {imm[20], imm[10:1], imm[11], imm[19:12], 12'd0};
      default: packed_inst = inst;
    endcase
  end

`ifdef IMM_ENC_RANGE_CHK_EN
  // A value fits N signed bits when everything from bit N-1 upward is a pure sign extension.
  logic fit12, fit13, fit21, fit_u;

  assign fit12 = (&imm[XLEN-1:11]) | ~(|imm[XLEN-1:11]);
  assign fit13 = (&imm[XLEN-1:12]) | ~(|imm[XLEN-1:12]);
  assign fit21 = (&imm[XLEN-1:20]) | ~(|imm[XLEN-1:20]);
  assign fit_u = (&imm[XLEN-1:31]) | ~(|imm[XLEN-1:31]);

  always_comb begin
    err = 1'b0;
    case (immsel)
      IMM_I, IMM_S: err = ~fit12;
      IMM_B:        err = ~fit13 | imm[0];
      IMM_J:        err = ~fit21 | imm[0];
      IMM_U:        err = (|imm[11:0]) | ~fit_u;
      default:      err = 1'b1;
    endcase
  end
`else
  logic unused_imm;

  assign unused_imm = ^imm;
  assign err        = 1'b0;
`endif

endmodule

// File: rtl/imm_encoder.sv
// Streaming immediate encoder: packs an immediate into an instruction and buffers it in a
// 2-entry FIFO. Optional range checking and error counting via IMM_ENC_RANGE_CHK_EN.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned ERRCNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_inst,
  input  logic [2:0]          in_immsel,
  input  logic [XLEN-1:0]     in_imm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_inst,
  output logic                out_err,
  output logic [ERRCNT_W-1:0] err_count
);

  logic [31:0] pack_inst;
  logic        pack_err;

  imm_pack #(
    .XLEN(XLEN)
  ) u_imm_pack (
    .inst        (in_inst),
    .immsel      (in_immsel),
    .imm         (in_imm),
    .packed_inst (pack_inst),
    .err         (pack_err)
  );

  logic [31:0] inst_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  count_q, count_d;
  logic        in_ready_q;
  logic        push, pop;

  assign push      = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = (count_q != 2'd0);
  assign out_inst  = inst_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_q[0]  <= '0;
      inst_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      in_ready_q <= 1'b1;
    end else begin
      if (push) begin
        inst_q[wr_ptr_q] <= pack_inst;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
      // Registered so in_ready never depends combinationally on out_ready.
      in_ready_q <= (count_d != 2'd2);
    end
  end

`ifdef IMM_ENC_RANGE_CHK_EN
  logic [1:0]          err_q;
  logic [ERRCNT_W-1:0] err_count_q;

  assign out_err   = err_q[rd_ptr_q];
  assign err_count = err_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q       <= 2'b00;
      err_count_q <= '0;
    end else begin
      if (push) begin
        err_q[wr_ptr_q] <= pack_err;
      end
      if (pop && out_err && !(&err_count_q)) begin
        err_count_q <= err_count_q + 1'b1;
      end
    end
  end
`else
  logic unused_err;

  assign unused_err = pack_err;
  assign out_err    = 1'b0;
  assign err_count  = '0;
`endif

endmodule
